// File: rtl/cmp_pkg.sv
// Shared types for the cascadable magnitude comparator slice.
package cmp_pkg;

  localparam int unsigned CMP_W = 8;

  // Operand word: index 0 is the most significant bit.
  typedef logic [0:CMP_W-1] cmp_word_t;

  // Cascade pair carried between bit cells and between stages.
  typedef struct packed {
    logic eq;
    logic gt;
  } cmp_casc_t;

  // Value injected at the top of a cascade: "all higher bits equal".
  localparam cmp_casc_t CASC_TOP = '{eq: 1'b1, gt: 1'b0};

endpackage

// File: rtl/cmp1_slice.sv
// One-bit combinational cascade cell; bits are walked from MSB to LSB.
module cmp1_slice (
  input  logic ai,
  input  logic bi,
  input  logic eq_in,
  input  logic gt_in,
  output logic eq_out,
  output logic gt_out
);

  // A pending "greater" wins; otherwise this bit can only decide if everything above tied.
  always_comb begin
    gt_out = gt_in | (eq_in & ai & ~bi);
    eq_out = eq_in & ~gt_in & ~(ai ^ bi);
  end

endmodule

// File: rtl/cmp8_cascade.sv
// Cascadable unsigned magnitude comparator with one registered output stage.
module cmp8_cascade
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             eq,
  input  logic             gt,
  output logic             out_valid,
  output logic             EQ,
  output logic             GT
);

  // chain[i] is the cascade state entering bit i; chain[WIDTH] is the result.
  cmp_casc_t chain [WIDTH+1];

  logic eq_d, eq_q;
  logic gt_d, gt_q;
  logic valid_d, valid_q;

  // Seed the bit chain from the cascade inputs of the more-significant stage.
  always_comb begin
    chain[0].eq = eq;
    chain[0].gt = gt;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cmp1_slice u_slice (
      .ai     (a[i]),
      .bi     (b[i]),
      .eq_in  (chain[i].eq),
      .gt_in  (chain[i].gt),
      .eq_out (chain[i+1].eq),
      .gt_out (chain[i+1].gt)
    );
  end

  // Capture a new result only on valid input; otherwise keep the last one so
  // operands presented while idle never reach the outputs.
  always_comb begin
    eq_d    = eq_q;
    gt_d    = gt_q;
    valid_d = in_valid;
    if (in_valid) begin
      eq_d = chain[WIDTH].eq;
      gt_d = chain[WIDTH].gt;
    end
  end

  // Output register with synchronous reset overriding any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q    <= '0;
      gt_q    <= '0;
      valid_q <= '0;
    end else begin
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      valid_q <= valid_d;
    end
  end

  assign EQ        = eq_q;
  assign GT        = gt_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cmp8_cascade.sv
// Self-checking bench for cmp8_cascade: directed steps, randomized stream
// against a numeric reference model, and a two-stage 16-bit chain.
module tb_cmp8_cascade;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic       eq, gt;
  logic       out_valid, EQ, GT;

  // Two-stage chain forming a 16-bit comparator.
  logic       h_valid;
  logic [7:0] h_a, h_b, l_a, l_b;
  logic       h_ov, h_eq, h_gt;
  logic       l_ov, l_eq, l_gt;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the outputs must show after the next edge.
  logic m_valid, m_eq, m_gt;

  cmp8_cascade #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .eq(eq), .gt(gt), .out_valid(out_valid), .EQ(EQ), .GT(GT)
  );

  cmp8_cascade #(.WIDTH(8)) u_hi (
    .clk(clk), .rst(rst), .in_valid(h_valid), .a(h_a), .b(h_b),
    .eq(1'b1), .gt(1'b0), .out_valid(h_ov), .EQ(h_eq), .GT(h_gt)
  );

  cmp8_cascade #(.WIDTH(8)) u_lo (
    .clk(clk), .rst(rst), .in_valid(h_ov), .a(l_a), .b(l_b),
    .eq(h_eq), .gt(h_gt), .out_valid(l_ov), .EQ(l_eq), .GT(l_gt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Reference model from the numeric rules: pending greater wins, a resolved
  // "less" sticks, otherwise compare the operand values.
  task automatic model_step();
    int unsigned va, vb;
    va = a;
    vb = b;
    if (rst) begin
      m_valid = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        if (gt)      begin m_gt = 1'b1;      m_eq = 1'b0;       end
        else if (eq) begin m_gt = (va > vb); m_eq = (va == vb); end
        else         begin m_gt = 1'b0;      m_eq = 1'b0;       end
      end
    end
  endtask

  // Advance one clock with the current inputs and compare against the model.
  task automatic tick_check(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".eq"},    EQ,        m_eq);
    check({tag, ".gt"},    GT,        m_gt);
    check({tag, ".excl"},  EQ & GT,   1'b0);
  endtask

  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ie, input logic ig);
    in_valid = v; a = ia; b = ib; eq = ie; gt = ig;
  endtask

  // Full 16-bit compare through the two-stage chain, checked against arithmetic.
  task automatic chain16(input logic [15:0] xa, input logic [15:0] xb);
    h_valid = 1'b1; h_a = xa[15:8]; h_b = xb[15:8];
    @(posedge clk); #1;
    h_valid = 1'b0; h_a = $urandom; h_b = $urandom;
    l_a = xa[7:0]; l_b = xb[7:0];
    @(posedge clk); #1;
    check("c16.valid", l_ov, 1'b1);
    check("c16.gt",    l_gt, xa > xb);
    check("c16.eq",    l_eq, xa == xb);
  endtask

  initial begin
    rst = 1'b1; h_valid = 1'b0;
    h_a = '0; h_b = '0; l_a = '0; l_b = '0;
    m_valid = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
    drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Reset for two cycles; inputs present during reset are discarded.
    tick_check("rst0");
    tick_check("rst1");
    rst = 1'b0;
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick_check("idle0");
    check("idle0.const", EQ | GT | out_valid, 1'b0);

    drive(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    tick_check("zero_eq");
    check("zero_eq.const", EQ & ~GT & out_valid, 1'b1);

    drive(1'b1, 8'b00000001, 8'h00, 1'b1, 1'b0);
    tick_check("lsb_one");
    check("lsb_one.const", GT & ~EQ, 1'b1);

    drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
    tick_check("gt_in");
    drive(1'b1, 8'h00, 8'h80, 1'b0, 1'b1);
    tick_check("gt_prio");
    check("gt_prio.const", GT & ~EQ, 1'b1);

    drive(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    tick_check("back_eq");
    check("back_eq.const", EQ & ~GT, 1'b1);
    drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick_check("lt_in");
    check("lt_in.const", EQ | GT, 1'b0);

    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    tick_check("ff_eq");
    check("ff_eq.const", EQ, 1'b1);
    drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick_check("ff_gt");
    check("ff_gt.const", GT, 1'b1);
    drive(1'b1, 8'h5A, 8'h5A, 1'b1, 1'b1);
    tick_check("illegal");
    check("illegal.const", GT & ~EQ, 1'b1);

    // Hold behaviour: results survive idle cycles with changing operands.
    drive(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
    tick_check("hold0");
    check("hold0.const", GT & ~out_valid, 1'b1);

    // Randomized stream with illegal cascade inputs, idle cycles and resets.
    for (int unsigned i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) b = a;
      tick_check("rand");
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick_check("settle");

    // 16-bit chain: boundaries, ties in the high byte, then random operands.
    chain16(16'h0000, 16'h0000);
    chain16(16'hFFFF, 16'hFFFF);
    chain16(16'h1234, 16'h1233);
    chain16(16'h1233, 16'h1234);
    chain16(16'h0100, 16'h00FF);
    chain16(16'h00FF, 16'h0100);
    for (int unsigned i = 0; i < 60; i++) begin
      logic [15:0] xa, xb;
      xa = 16'($urandom);
      xb = ($urandom_range(0, 1) == 0) ? {xa[15:8], 8'($urandom)} : 16'($urandom);
      chain16(xa, xb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp8_cascade.md
Name: cmp8_cascade

Overview:
- 8-bit cascadable unsigned magnitude comparator with registered outputs.
- Compares operands a and b, qualified by cascade inputs eq and gt from a more-significant stage.
- Produces cascade outputs EQ and GT for a less-significant stage, or for final use.
- Used as a slice for building wider comparators; chained stages each add one cycle of latency.

Parameters:
- WIDTH, 8, operand width in bits. Index 0 is the MSB, i.e. operands are declared [0:WIDTH-1].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a, b, eq, gt this cycle
- a  input  WIDTH  operand A, unsigned; bit 0 is most significant
- b  input  WIDTH  operand B, unsigned; bit 0 is most significant
- eq  input  1  cascade-in: higher-order bits were equal (tie to 1 for the top stage)
- gt  input  1  cascade-in: higher-order bits already made A greater (tie to 0 for the top stage)
- out_valid  output  1  EQ/GT hold a new result
- EQ  output  1  cascade-out: A equals B, including higher-order bits
- GT  output  1  cascade-out: A is greater than B, including higher-order bits

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Combinational function, with cmp_gt = (a > b unsigned) and cmp_eq = (a == b):
  - GT_next = gt | (eq & ~gt & cmp_gt)
  - EQ_next = eq & ~gt & cmp_eq
- gt has priority over eq. The illegal input eq=1, gt=1 is treated as gt=1: GT=1, EQ=0.
- eq=0, gt=0 means a higher stage resolved A<B: GT=0, EQ=0 regardless of a and b.
- EQ and GT are never both 1.
- Derived less-than is ~EQ & ~GT. It is not a port.
- Latency is exactly 1 cycle. On a clk edge with in_valid=1, EQ/GT register EQ_next/GT_next and out_valid=1.
- With in_valid=0: EQ/GT hold their last value and out_valid=0 on the next cycle.
- Reset: while rst=1 at a clk edge, EQ=0, GT=0, out_valid=0. rst overrides in_valid. Inputs present during the reset cycle are discarded.
- Reset mid-stream: the result in flight is lost. The first post-reset result appears 1 cycle after the first in_valid.
- Bit ordering: a = 8'b00000001 sets a[7], the LSB, so value 1. Comparison is on numeric value.
- Boundaries:
  - a = b = 0 and a = b = 0xFF yield EQ = eq & ~gt.
  - a=0xFF, b=0x00 with eq=1, gt=0 gives GT=1.
- No X propagation from in_valid=0 inputs into EQ/GT.

Decomposition:
- Shared package cmp_pkg:
  - localparam CMP_W = 8
  - typedef logic [0:CMP_W-1] cmp_word_t
  - typedef struct {logic eq; logic gt;} cmp_casc_t
- One natural sub-module, cmp1_slice: a 1-bit combinational cascade cell.
  - Inputs: ai, bi, eq_in, gt_in. Outputs: eq_out, gt_out.
  - gt_out = gt_in | (eq_in & ai & ~bi)
  - eq_out = eq_in & ~gt_in & ~(ai ^ bi)
- Instantiate WIDTH slices chained from bit 0 (MSB) to bit WIDTH-1 (LSB), then a single output register stage.
- The structural chain must match the behavioural equations above bit-for-bit.

Test Plan:
- rst=1 for 2 cycles, then release -> EQ=0, GT=0, out_valid=0 until the first in_valid.
- a=0x00, b=0x00, eq=1, gt=0, in_valid=1 -> next cycle EQ=1, GT=0, out_valid=1.
- a=0x01 (8'b00000001), b=0x00, eq=1, gt=0 -> EQ=0, GT=1.
- a=0x01, b=0x00, eq=0, gt=1 -> EQ=0, GT=1. Then a=0x00, b=0x80, eq=0, gt=1 -> still GT=1, EQ=0 (cascade priority).
- a=0x00, b=0x00, eq=1, gt=0 after GT case -> EQ=1, GT=0. Then eq=0, gt=0, a=0xFF, b=0x00 -> EQ=0, GT=0.
- Randomized 1000 vectors, including eq=gt=1, in_valid toggling and rst asserted mid-stream -> outputs match the reference equations one cycle later and are never EQ=GT=1. Also check a cmp8_cascade chain equivalent to a 16-bit compare.
